// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared encodings for the sequential multiply/divide unit.
package mdu_seq_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign diff    = shifted - {2'b00, divisor_i};
    // Sign bit of the trial difference decides keep vs. restore.
    assign rem_o   = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    assign quot_o  = {quot_i[WIDTH-2:0], ~diff[WIDTH+1]};

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned multiply/divide, one bit per cycle, with a
// start/busy/done handshake and register-file write-back outputs.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     src_a_i,
    input  logic [WIDTH-1:0]     src_b_i,
    input  logic [REG_IDX_W-1:0] dest_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 reg_write_o,
    output logic [REG_IDX_W-1:0] w_reg_out_o,
    output logic [WIDTH-1:0]     result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic [REG_IDX_W-1:0] w_reg_q, w_reg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       step_rem;
    logic [WIDTH-1:0]     step_quot;
    logic [WIDTH-1:0]     sel;
    logic                 div_zero;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Multiplier sits in the low half of prod_q and is consumed from bit 0.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? a_q : {WIDTH{1'b0}}};
    assign div_zero = op_i[1] && (src_b_i == '0);
    assign sel      = (op_q == MDU_MUL)   ? prod_q[WIDTH-1:0] :
                      (op_q == MDU_MULHU) ? prod_q[2*WIDTH-1:WIDTH] :
                      (op_q == MDU_DIVU)  ? quot_q : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dest_d   = dest_q;
        w_reg_d  = w_reg_q;
        result_d = result_q;
        if (state_q == ST_IDLE && start_i) begin
            state_d = div_zero ? ST_DONE : ST_BUSY;
            op_d    = mdu_op_e'(op_i);
            cnt_d   = '0;
            a_d     = src_a_i;
            b_d     = src_b_i;
            dest_d  = dest_i;
            prod_d  = {{WIDTH{1'b0}}, src_b_i};
            // Divide by zero preloads the architected results directly.
            rem_d   = div_zero ? {1'b0, src_a_i} : '0;
            quot_d  = div_zero ? {WIDTH{1'b1}} : src_a_i;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[1]) begin
                rem_d  = step_rem;
                quot_d = step_quot;
            end else begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
        end else if (state_q == ST_DONE) begin
            state_d  = ST_IDLE;
            w_reg_d  = dest_q;
            result_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dest_q   <= '0;
            w_reg_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dest_q   <= dest_d;
            w_reg_q  <= w_reg_d;
            result_q <= result_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign reg_write_o = done_o && (dest_q != '0);
    assign w_reg_out_o = done_o ? dest_q : w_reg_q;
    assign result_o    = done_o ? sel : result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed table, hand-written corner sequences and random ops
// checked against an arithmetic reference model.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic [4:0]  dest_i = '0;
    logic        ready_o, busy_o, done_o, reg_write_o;
    logic [4:0]  w_reg_out_o;
    logic [31:0] result_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .src_a_i     (src_a_i),
        .src_b_i     (src_b_i),
        .dest_i      (dest_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .reg_write_o (reg_write_o),
        .w_reg_out_o (w_reg_out_o),
        .result_o    (result_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 100 && !ready_o; k++) begin
            @(posedge clk); #1;
        end
        check(tag, "ready_before_start", ready_o, 1);
    endtask

    // Issues one op in cycle 0, then follows it to its done pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic [31:0] res;
        logic [4:0]  w;
        logic        rw;
        bit          busy_ok;
        lat = 0; res = '0; w = '0; rw = 1'b0; busy_ok = 1'b1;
        wait_ready(tag);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; dest_i = d;
        @(posedge clk); #1;
        start_i = 1'b0; src_a_i = $urandom; src_b_i = $urandom; dest_i = 5'($urandom);
        for (int k = 1; k <= 100; k++) begin
            if (!busy_o || ready_o) busy_ok = 1'b0;
            if (done_o) begin
                lat = k; res = result_o; w = w_reg_out_o; rw = reg_write_o;
                break;
            end
            @(posedge clk); #1;
        end
        check(tag, "latency", lat, exp_lat);
        check(tag, "result", res, exp_res);
        check(tag, "w_reg_out", w, d);
        check(tag, "reg_write", rw, d != 0);
        check(tag, "busy_span", busy_ok, 1);
        @(posedge clk); #1;
        check(tag, "done_pulse_ends", done_o, 0);
        check(tag, "ready_after_done", ready_o, 1);
        check(tag, "result_holds", result_o, exp_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   n_done, done_cyc, rw_seen;
        bit   ready_low_ok;
        logic [31:0] res_seen, a, b;
        logic [1:0]  op;

        vecs[0] = '{2'b00, 32'd7,          32'd8,          5'd3,  32'h0000_0038, 33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFE, 33};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'h0000_0001, 33};
        vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd6,  32'h0000_000E, 33};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd7,  32'h0000_0002, 33};
        vecs[5] = '{2'b10, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF, 1};
        vecs[6] = '{2'b11, 32'd5,          32'd0,          5'd9,  32'h0000_0005, 1};
        vecs[7] = '{2'b00, 32'd12,         32'd11,         5'd0,  32'h0000_0084, 33};
        vecs[8] = '{2'b10, 32'd3,          32'd10,         5'd31, 32'h0000_0000, 33};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", "ready", ready_o, 1);
        check("reset", "busy", busy_o, 0);
        check("reset", "done", done_o, 0);
        check("reset", "reg_write", reg_write_o, 0);
        check("reset", "w_reg_out", w_reg_out_o, 0);
        check("reset", "result", result_o, 0);

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].res, vecs[i].lat);

        // Start during flight and during DONE must both be dropped.
        wait_ready("inflight");
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd7; src_b_i = 32'd8; dest_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_done = 0; done_cyc = 0; res_seen = '0; ready_low_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (done_o) begin n_done++; done_cyc = k; res_seen = result_o; end
            if (k <= 33 && ready_o) ready_low_ok = 1'b0;
            if (k == 34) check("inflight", "ready_at_34", ready_o, 1);
            if (k == 35) check("inflight", "start_in_done_ignored", busy_o, 0);
            start_i = (k == 10 || k == 33);
            if (k == 10) begin op_i = 2'b10; src_a_i = 32'd99; src_b_i = 32'd3; dest_i = 5'd9; end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check("inflight", "done_count", n_done, 1);
        check("inflight", "done_cycle", done_cyc, 33);
        check("inflight", "result", res_seen, 32'h38);
        check("inflight", "ready_low", ready_low_ok, 1);

        // Reset in the middle of a divide aborts it silently.
        wait_ready("midrst");
        start_i = 1'b1; op_i = 2'b10; src_a_i = 32'd1000; src_b_i = 32'd3; dest_i = 5'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst", "ready", ready_o, 1);
        check("midrst", "busy", busy_o, 0);
        check("midrst", "result", result_o, 0);
        n_done = 0; rw_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) n_done++;
            if (reg_write_o) rw_seen++;
            @(posedge clk); #1;
        end
        check("midrst", "no_done", n_done, 0);
        check("midrst", "no_reg_write", rw_seen, 0);
        run_op("after_rst", 2'b00, 32'd12, 32'd11, 5'd5, 32'd132, 33);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom;
            run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom_range(0, 31)), model(op, a, b),
                   (op[1] && b == 0) ? 1 : 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative unsigned multiply/divide unit in the execute stage.
- Consumes the two register-file read operands (`r_data1`, `r_data2`) and produces a result plus destination index for the register-file write port.
- One bit per cycle, shift-add for multiply and restoring for divide.
- Exposes a start/busy/done handshake so the control FSM stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two, at least 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- op  in  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder)
- src_a  in  WIDTH  multiplicand / dividend (from r_data1)
- src_b  in  WIDTH  multiplier / divisor (from r_data2)
- dest  in  5  destination register index
- ready  out  1  high in IDLE only
- busy  out  1  high in BUSY and DONE
- done  out  1  one-cycle pulse with valid result
- reg_write  out  1  write strobe to the register file (RegWrite)
- w_reg_out  out  5  destination index, valid while done=1
- result  out  WIDTH  write data, valid while done=1

Behaviour:
- FSM states:
  - IDLE: ready=1.
  - BUSY: one iteration per cycle, cnt counts 0..WIDTH-1.
  - DONE: one cycle, then back to IDLE.
- Reset: state=IDLE, cnt=0, accumulators=0. Outputs after reset: ready=1, busy=0, done=0, reg_write=0, w_reg_out=0, result=0.
- Start acceptance: start=1 in IDLE captures src_a, src_b, op and dest.
  - Normal case: go to BUSY.
  - Divide by zero (op[1]=1 and src_b=0): go straight to DONE.
- Latency:
  - Normal: done is high exactly WIDTH+1 cycles after the accept cycle, i.e. cycle 33 for WIDTH=32.
  - Divide by zero: done is high 1 cycle after the accept cycle.
- Multiply:
  - 2*WIDTH product register.
  - Each BUSY cycle: if multiplier LSB=1, add the multiplicand into the upper half; then shift right by 1, keeping the carry.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- Divide (restoring):
  - Remainder register WIDTH+1 bits.
  - Each cycle: shift {rem, quot} left by 1; trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set quot LSB=1; otherwise restore.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide-by-zero results: DIVU gives all-ones; REMU gives src_a.
- No overflow case exists, since all operations are unsigned.
- DONE cycle: done=1; reg_write=1 unless dest=0 (the write is suppressed, done still pulses); result and w_reg_out are driven.
- Outside DONE: result and w_reg_out hold their last values; reg_write=0.
- start while busy=1 is ignored; there is no queuing.
- Operands are captured at accept time; later changes to src_a, src_b or dest have no effect.
- start in the same cycle as DONE is ignored; ready rises the following cycle.
- rst mid-operation: the next cycle is IDLE with no done or reg_write pulse for the aborted operation; result is cleared to 0.

Decomposition:
- Shared package (cpu_pkg): the MDU op encodings (MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU), the FSM state constants, and REG_IDX_W=5.
- One sub-module is natural: mdu_div_step, a combinational single restoring-divide iteration (rem_in, quot_in, divisor -> rem_out, quot_out). It is reusable if a radix-4 variant is built later.
- The multiply datapath stays inline.

Test Plan:
- MUL 7*8, dest=3: accept at cycle 0 -> done=1 at cycle 33, result=0x00000038, w_reg_out=3, reg_write=1; busy high for cycles 1-33.
- MULHU and MUL of 0xFFFFFFFF by 0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; both with 33-cycle latency.
- DIVU 5/0 -> done at cycle 1 with result=0xFFFFFFFF; REMU 5/0 -> result=0x00000005.
- start pulsed at cycle 10 during a MUL in flight -> ignored: exactly one done, at cycle 33; ready=0 until cycle 34. MUL with dest=0 -> done=1, reg_write=0.
- rst asserted at cycle 12 of a DIVU -> cycle 13: ready=1, busy=0, result=0; no done or reg_write in the following 40 cycles. A new MUL then returns the correct value.
